mux_stream_rr: RTL and testbench
================================

Name: mux_stream_rr

Overview:
- Parametrised N-input, WIDTH-bit stream multiplexer with valid/ready handshake on every input and on the output.
- Operates in one of two modes:
  - Fixed-select (sel-driven, like a classic 4x1 mux).
  - Round-robin arbitration across all requesting inputs.
- Output is registered, giving 1-cycle latency.
- Sits between parallel producer channels (ADC/UART/counter streams) and a single shared consumer (display driver, serial TX).

Parameters:
- WIDTH, 4, data width per channel in bits (>=1).
- N_IN, 4, number of input channels (2..16).
- SEL_W, $clog2(N_IN), select/channel-index width; derived, not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  N_IN*WIDTH  packed inputs; channel i at bits [i*WIDTH +: WIDTH].
- in_valid  input  N_IN  per-channel valid.
- in_ready  output  N_IN  per-channel ready (combinational, one-hot or zero).
- out_data  output  WIDTH  registered output data.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.

Behaviour:

Reset:
- Synchronous, on a rising edge with rst=1.
- Reset values: out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
- in_ready=all-zero while rst=1.

Handshakes:
- load_en = !out_valid || out_ready.
- A transfer on input i occurs when in_valid[i] && in_ready[i]; on output when out_valid && out_ready.

Arbitration (combinational, only evaluated when load_en=1):
- mode=0: grant = sel if sel < N_IN and in_valid[sel]=1; otherwise no grant. Requests on other channels are ignored.
- mode=1: grant = first i with in_valid[i]=1, scanning ptr, ptr+1, ... N_IN-1, 0, ... ptr-1 (mod N_IN). No requester means no grant.
- in_ready[g]=1 only for granted g; all other bits 0.
- At most one in_ready bit is set in any cycle.

Register update on a clock edge with rst=0:
- If load_en and a grant exists: out_data <= in_data[g]; out_ch <= g; out_valid <= 1.
- If load_en and no grant: out_valid <= 0; out_data and out_ch hold.
- If !load_en (out_valid && !out_ready): all output registers hold. out_data/out_ch must stay stable while stalled.

Round-robin pointer:
- Updated only on a grant in mode=1: ptr <= (g+1) mod N_IN. Wrap from N_IN-1 to 0.
- Unchanged in mode=0 and when there is no grant.

Throughput and latency:
- 1 beat/cycle sustained when out_ready=1 continuously.
- Input accepted in cycle t appears on out_* in cycle t+1.

Boundary conditions:
- Simultaneous output drain and new input grant in the same cycle: the new beat is loaded; no bubble.
- mode or sel change: takes effect at the next arbitration. A beat already held in the output register is not affected.
- sel >= N_IN (N_IN not a power of 2): no grant, in_ready=0.
- in_valid dropping without a handshake is the producer's fault. The block still never grants a channel whose valid is low in the current cycle.
- rst asserted mid-stall: pending output beat is discarded; out_valid=0 the next cycle.

Test Plan (WIDTH=4, N_IN=4 unless stated):
1. Reset: assert rst 2 cycles with all in_valid=1 -> in_ready=0000 during reset; out_valid=0, out_data=0, out_ch=0 after reset.
2. Fixed mode: mode=0, sel=2, in_data ch0..3 = 1,5,A,F, all valid, out_ready=1 -> in_ready=0100 every cycle; out_data=A, out_ch=2 from the cycle after; no other channel ever granted.
3. Round-robin fairness: mode=1, all 4 valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1... with out_data matching; one beat per cycle, no bubbles.
4. Backpressure: mode=1, ch1 valid data=7, out_ready=0 for 3 cycles -> out_valid=1, out_data=7, out_ch=1 held stable; in_ready=0000 during stall. out_ready=1 -> ch3 (data=C) granted the same cycle, out_data=C next cycle.
5. Sparse requests with wrap: mode=1, ptr=3, only ch3 and ch0 valid -> grant ch3, then ch0 (wrap), then ch3; ptr ends at 0 after the ch3 grant.
6. Reset mid-operation and N_IN=3: WIDTH=8, N_IN=3, mode=0, sel=3 -> no grant, out_valid=0. sel=1 while streaming with out_ready=0, then rst pulse -> out_valid=0 the next cycle; ptr=0 afterwards.

Source files
------------

// File: rtl/mux_stream_rr.sv
// N-input valid/ready stream multiplexer with a registered output stage.
// Channel choice is either a fixed select or round-robin across all requesters.
module mux_stream_rr #(
    parameter int WIDTH = 4,
    parameter int N_IN  = 4,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN - 1);

    logic                 load_en_s;
    logic                 grant_valid_s;
    logic [SEL_W-1:0]     grant_idx_s;
    logic [WIDTH-1:0]     grant_data_s;
    logic [SEL_W-1:0]     ptr_next_s;
    logic [N_IN-1:0]      in_ready_s;
    logic [SEL_W-1:0]     ptr_r;
    logic [WIDTH-1:0]     out_data_r;
    logic [SEL_W-1:0]     out_ch_r;
    logic                 out_valid_r;

    assign load_en_s = !out_valid_r || out_ready;

    // Arbitration: pick at most one valid channel when the output stage can load.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {SEL_W{1'b0}};
        grant_data_s  = {WIDTH{1'b0}};
        if (rst || !load_en_s) begin
            grant_valid_s = 1'b0;
        end else if (mode == 1'b0) begin
            // An out-of-range sel never matches any loop index, so it yields no grant.
            for (int i = 0; i < N_IN; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = SEL_W'(i);
                    grant_data_s  = in_data[i*WIDTH +: WIDTH];
                end else begin
                    grant_valid_s = grant_valid_s;
                end
            end
        end else begin
            // Two passes give the circular scan: ptr..N_IN-1, then 0..ptr-1.
            for (int i = 0; i < N_IN; i++) begin
                if (!grant_valid_s && in_valid[i] && i >= int'(ptr_r)) begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = SEL_W'(i);
                    grant_data_s  = in_data[i*WIDTH +: WIDTH];
                end else begin
                    grant_valid_s = grant_valid_s;
                end
            end
            for (int i = 0; i < N_IN; i++) begin
                if (!grant_valid_s && in_valid[i] && i < int'(ptr_r)) begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = SEL_W'(i);
                    grant_data_s  = in_data[i*WIDTH +: WIDTH];
                end else begin
                    grant_valid_s = grant_valid_s;
                end
            end
        end
    end

    // One-hot ready decode from the grant.
    always_comb begin
        in_ready_s = {N_IN{1'b0}};
        for (int i = 0; i < N_IN; i++) begin
            if (grant_valid_s && grant_idx_s == SEL_W'(i)) begin
                in_ready_s[i] = 1'b1;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    // Round-robin pointer advances past the granted channel, wrapping at N_IN.
    always_comb begin
        ptr_next_s = grant_idx_s + SEL_W'(1'b1);
        if (grant_idx_s == LAST_IDX) begin
            ptr_next_s = {SEL_W{1'b0}};
        end else begin
            ptr_next_s = grant_idx_s + SEL_W'(1'b1);
        end
    end

    // Output register stage and round-robin pointer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_ch_r    <= {SEL_W{1'b0}};
            ptr_r       <= {SEL_W{1'b0}};
        end else begin
            if (load_en_s && grant_valid_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= grant_data_s;
                out_ch_r    <= grant_idx_s;
            end else if (load_en_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (grant_valid_s && mode == 1'b1) begin
                ptr_r <= ptr_next_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Directed bench for mux_stream_rr: a 4x4-bit instance for most scenarios and
// an 8-bit, 3-channel instance for the non-power-of-two select and reset cases.
module tb_mux_stream_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        rst, mode, out_ready, out_valid;
    logic [1:0]  sel, out_ch;
    logic [15:0] in_data;
    logic [3:0]  in_valid, in_ready, out_data;

    logic        rst_b, mode_b, out_ready_b, out_valid_b;
    logic [1:0]  sel_b, out_ch_b;
    logic [23:0] in_data_b;
    logic [2:0]  in_valid_b, in_ready_b;
    logic [7:0]  out_data_b;

    mux_stream_rr #(.WIDTH(4), .N_IN(4)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_stream_rr #(.WIDTH(8), .N_IN(3)) u_dut3 (
        .clk(clk), .rst(rst_b), .mode(mode_b), .sel(sel_b), .in_data(in_data_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b),
        .out_ch(out_ch_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; sel = 2'd0; in_data = 16'hFA51; in_valid = 4'hF; out_ready = 1'b1;
        rst_b = 1'b1; mode_b = 1'b1; sel_b = 2'd0; in_data_b = 24'h332211; in_valid_b = 3'b111; out_ready_b = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
            checks++; if (in_ready_b !== 3'b000) begin failures++; $display("FAIL reset_in_ready_b got=%b exp=000", in_ready_b); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 4'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_ch !== 2'd0) begin failures++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
        checks++; if (out_valid_b !== 1'b0) begin failures++; $display("FAIL reset_out_valid_b got=%b exp=0", out_valid_b); end
        rst = 1'b0; in_valid = 4'h0;
        rst_b = 1'b0; in_valid_b = 3'b000;
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_data = 16'hFA51; in_valid = 4'hF; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL fixed_in_ready cyc=%0d got=%b exp=0100", c, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 4'hA || out_ch !== 2'd2) begin
                failures++; $display("FAIL fixed_out cyc=%0d got v=%b d=%h ch=%0d exp v=1 d=a ch=2", c, out_valid, out_data, out_ch);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] data_tab [4];
        logic [3:0] exp_rdy;
        data_tab[0] = 4'h1; data_tab[1] = 4'h5; data_tab[2] = 4'hA; data_tab[3] = 4'hF;
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            #1;
            checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rr_in_ready k=%0d got=%b exp=%b", k, in_ready, exp_rdy); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) || out_data !== data_tab[k % 4]) begin
                failures++; $display("FAIL rr_out k=%0d got v=%b d=%h ch=%0d exp v=1 d=%h ch=%0d", k, out_valid, out_data, out_ch, data_tab[k % 4], k % 4);
            end
        end
        in_valid = 4'h0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        mode = 1'b1; in_data = 16'hC070; in_valid = 4'b0010; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL bp_first_ready got=%b exp=0010", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 4'h7 || out_ch !== 2'd1) begin
            failures++; $display("FAIL bp_load got v=%b d=%h ch=%0d exp v=1 d=7 ch=1", out_valid, out_data, out_ch);
        end
        in_valid = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_stall_ready cyc=%0d got=%b exp=0000", c, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 4'h7 || out_ch !== 2'd1) begin
                failures++; $display("FAIL bp_hold cyc=%0d got v=%b d=%h ch=%0d exp v=1 d=7 ch=1", c, out_valid, out_data, out_ch);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b1000) begin failures++; $display("FAIL bp_release_ready got=%b exp=1000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 4'hC || out_ch !== 2'd3) begin
            failures++; $display("FAIL bp_release_out got v=%b d=%h ch=%0d exp v=1 d=c ch=3", out_valid, out_data, out_ch);
        end
        in_valid = 4'h0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_sparse_wrap();
        logic [3:0] exp_rdy [4];
        logic [3:0] exp_dat [4];
        logic [1:0] exp_ch  [4];
        exp_rdy[0] = 4'b1000; exp_rdy[1] = 4'b0001; exp_rdy[2] = 4'b1000; exp_rdy[3] = 4'b0001;
        exp_dat[0] = 4'hD;    exp_dat[1] = 4'h2;    exp_dat[2] = 4'hD;    exp_dat[3] = 4'h2;
        exp_ch[0]  = 2'd3;    exp_ch[1]  = 2'd0;    exp_ch[2]  = 2'd3;    exp_ch[3]  = 2'd0;
        mode = 1'b1; in_data = 16'hD002; out_ready = 1'b1;
        in_valid = 4'b0100;
        #1;
        checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL sparse_setup_ready got=%b exp=0100", in_ready); end
        tick();
        in_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (in_ready !== exp_rdy[k]) begin failures++; $display("FAIL sparse_ready k=%0d got=%b exp=%b", k, in_ready, exp_rdy[k]); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== exp_dat[k] || out_ch !== exp_ch[k]) begin
                failures++; $display("FAIL sparse_out k=%0d got v=%b d=%h ch=%0d exp v=1 d=%h ch=%0d", k, out_valid, out_data, out_ch, exp_dat[k], exp_ch[k]);
            end
        end
        in_valid = 4'h0;
        tick();
    endtask

    task automatic test_reset_mid_n3();
        mode_b = 1'b0; sel_b = 2'd3; in_data_b = 24'h332211; in_valid_b = 3'b111; out_ready_b = 1'b1;
        #1;
        checks++; if (in_ready_b !== 3'b000) begin failures++; $display("FAIL n3_sel3_ready got=%b exp=000", in_ready_b); end
        tick();
        checks++; if (out_valid_b !== 1'b0) begin failures++; $display("FAIL n3_sel3_valid got=%b exp=0", out_valid_b); end
        sel_b = 2'd1;
        #1;
        checks++; if (in_ready_b !== 3'b010) begin failures++; $display("FAIL n3_sel1_ready got=%b exp=010", in_ready_b); end
        tick();
        checks++; if (out_valid_b !== 1'b1 || out_data_b !== 8'h22 || out_ch_b !== 2'd1) begin
            failures++; $display("FAIL n3_sel1_out got v=%b d=%h ch=%0d exp v=1 d=22 ch=1", out_valid_b, out_data_b, out_ch_b);
        end
        mode_b = 1'b1; in_valid_b = 3'b010;
        #1;
        checks++; if (in_ready_b !== 3'b010) begin failures++; $display("FAIL n3_rr_ready got=%b exp=010", in_ready_b); end
        tick();
        out_ready_b = 1'b0; in_valid_b = 3'b111;
        #1;
        checks++; if (in_ready_b !== 3'b000) begin failures++; $display("FAIL n3_stall_ready got=%b exp=000", in_ready_b); end
        tick();
        checks++; if (out_valid_b !== 1'b1 || out_data_b !== 8'h22 || out_ch_b !== 2'd1) begin
            failures++; $display("FAIL n3_stall_hold got v=%b d=%h ch=%0d exp v=1 d=22 ch=1", out_valid_b, out_data_b, out_ch_b);
        end
        rst_b = 1'b1;
        #1;
        checks++; if (in_ready_b !== 3'b000) begin failures++; $display("FAIL n3_rst_ready got=%b exp=000", in_ready_b); end
        tick();
        checks++; if (out_valid_b !== 1'b0 || out_data_b !== 8'h00 || out_ch_b !== 2'd0) begin
            failures++; $display("FAIL n3_rst_out got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", out_valid_b, out_data_b, out_ch_b);
        end
        rst_b = 1'b0; out_ready_b = 1'b1;
        #1;
        checks++; if (in_ready_b !== 3'b001) begin failures++; $display("FAIL n3_ptr_after_rst got=%b exp=001", in_ready_b); end
        tick();
        checks++; if (out_valid_b !== 1'b1 || out_data_b !== 8'h11 || out_ch_b !== 2'd0) begin
            failures++; $display("FAIL n3_post_rst_out got v=%b d=%h ch=%0d exp v=1 d=11 ch=0", out_valid_b, out_data_b, out_ch_b);
        end
        in_valid_b = 3'b000;
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_sparse_wrap();
        test_reset_mid_n3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
